// File: rtl/sram_ctl_pkg.sv
// Shared types and helpers for the async SRAM initiator.
package sram_ctl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StHold   = 2'd3
    } state_e;

    // Wait-counter width large enough to hold the longest phase length minus one.
    function automatic int unsigned ctr_width(input int unsigned setup_cyc,
                                              input int unsigned access_cyc,
                                              input int unsigned hold_cyc);
        int unsigned m;
        m = setup_cyc;
        if (access_cyc > m) m = access_cyc;
        if (hold_cyc > m) m = hold_cyc;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sram_ctl_if.sv
// Host-side single-beat request/response channel of the SRAM initiator.
interface sram_ctl_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_wait_ctr.sv
// Loadable down-counter that saturates at zero and flags it.
module sram_wait_ctr #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/sram_ctl.sv
// Clocked initiator for an asynchronous SRAM: one host beat becomes a registered
// SETUP / ACCESS / HOLD strobe sequence on nce/noe/nwe with a tri-stated data bus.
module sram_ctl
    import sram_ctl_pkg::*;
#(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 8,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned ACCESS_CYC = 4,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic          clk,
    input  logic          reset,
    sram_ctl_if.slave     host,
    output logic [AW-1:0] a,
    inout  wire  [DW-1:0] d,
    output logic          nce,
    output logic          noe,
    output logic          nwe
);
    localparam int unsigned CW = ctr_width(SETUP_CYC, ACCESS_CYC, HOLD_CYC);
    localparam logic [CW-1:0] SetupLd  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] AccessLd = CW'(ACCESS_CYC - 1);
    localparam logic [CW-1:0] HoldLd   = CW'(HOLD_CYC - 1);

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [DW-1:0] d_q;
    logic          d_oe;
    logic          ready_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          accept;
    logic          ctr_load;
    logic [CW-1:0] ctr_val;
    logic          ctr_zero;

    logic          nce_d, noe_d, nwe_d, d_oe_d, ready_d, capture;

    assign accept = host.req_valid & ready_q;
    assign we_d   = accept ? host.req_we : we_q;

    sram_wait_ctr #(
        .WIDTH (CW)
    ) u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (ctr_val),
        .zero     (ctr_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every phase is reloaded with its length minus one on entry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept)   state_d = StSetup;
            StSetup:  if (ctr_zero) state_d = StAccess;
            StAccess: if (ctr_zero) state_d = StHold;
            StHold:   if (ctr_zero) state_d = StIdle;
        endcase

        ctr_load = (state_d != state_q);
        ctr_val  = '0;
        unique case (state_d)
            StIdle:   ctr_val = '0;
            StSetup:  ctr_val = SetupLd;
            StAccess: ctr_val = AccessLd;
            StHold:   ctr_val = HoldLd;
        endcase
    end

    // Output decode from the upcoming state so every bus pin leaves a flop.
    always_comb begin
        nce_d   = (state_d == StIdle);
        noe_d   = !((state_d == StAccess) && !we_d);
        nwe_d   = !((state_d == StAccess) && we_d);
        d_oe_d  = (state_d != StIdle) && we_d;
        ready_d = (state_d == StIdle);
        capture = (state_q == StAccess) && (state_d == StHold) && !we_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q        <= 1'b0;
            a           <= '0;
            d_q         <= '0;
            d_oe        <= 1'b0;
            nce         <= 1'b1;
            noe         <= 1'b1;
            nwe         <= 1'b1;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            we_q        <= we_d;
            if (accept) begin
                a   <= host.req_addr;
                d_q <= host.req_wdata;
            end
            d_oe        <= d_oe_d;
            nce         <= nce_d;
            noe         <= noe_d;
            nwe         <= nwe_d;
            ready_q     <= ready_d;
            rsp_valid_q <= capture;
            if (capture) begin
                rsp_rdata_q <= d;
            end
        end
    end

    assign host.req_ready = ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;

    assign d = d_oe ? d_q : {DW{1'bz}};
endmodule
